qpp_interleaver: RTL and testbench

Buffer stage directly downstream of the SISO decoder (top). It captures the decoder's extrinsic stream for one code block in natural order and replays it in LTE QPP-interleaved order, or deinterleaved order, as the a-priori stream for the next half-iteration. The buffer is single-bank: fill, then drain. Addresses come from a recursive QPP generator, so no multipliers or address tables are needed.

---
 rtl/qpp_pkg.sv | 32 +++
 rtl/qpp_if.sv | 30 +++
 rtl/qpp_addr_gen.sv | 52 +++++
 rtl/qpp_interleaver.sv | 212 +++++++++++++++++++++
 tb/tb_qpp_interleaver.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/qpp_pkg.sv
// Shared constants, FSM state type and the modular-add helper for the QPP interleaver buffer.
package qpp_pkg;

    localparam int DW   = 16;
    localparam int KMAX = 6144;
    localparam int KMIN = 40;
    localparam int AW   = 13;

    localparam logic [AW:0] CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        PREP  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    // (a + b) mod k for a, b < k: one carry-extended add and a single conditional subtract
    function automatic logic [AW-1:0] mod_add(input logic [AW-1:0] a,
                                              input logic [AW-1:0] b,
                                              input logic [AW-1:0] k);
        logic [AW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= {1'b0, k}) begin
            mod_add = AW'(sum - {1'b0, k});
        end else begin
            mod_add = sum[AW-1:0];
        end
    endfunction

endpackage

// File: rtl/qpp_if.sv
// Configuration, extrinsic input and apriori output bundle of the QPP interleaver buffer.
interface qpp_if;
    import qpp_pkg::*;

    logic [15:0]   blklen;
    logic [15:0]   f1;
    logic [15:0]   f2;
    logic          deint;
    logic          valid_blklen;
    logic [DW-1:0] extrinsic;
    logic          valid_extrinsic;
    logic [DW-1:0] apriori;
    logic          valid_apriori;
    logic          ready_apriori;
    logic          busy;
    logic          done;
    logic          cfg_err;
    logic          ovf_err;

    modport slave (
        input  blklen, f1, f2, deint, valid_blklen, extrinsic, valid_extrinsic, ready_apriori,
        output apriori, valid_apriori, busy, done, cfg_err, ovf_err
    );

    modport master (
        output blklen, f1, f2, deint, valid_blklen, extrinsic, valid_extrinsic, ready_apriori,
        input  apriori, valid_apriori, busy, done, cfg_err, ovf_err
    );

endinterface

// File: rtl/qpp_addr_gen.sv
// Recursive QPP address generator: pi(i) = (f1*i + f2*i^2) mod K using only modular adds.
module qpp_addr_gen
    import qpp_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] k,
    input  logic [AW-1:0] f1,
    input  logic [AW-1:0] f2,
    input  logic          init,
    input  logic          step,
    output logic [AW-1:0] addr
);

    logic [AW-1:0] pi_q, pi_d, g_q, g_d, d_q, d_d;
    logic [AW-1:0] pi_s, g_s;

    // init restarts at pi(0); a step in the same cycle consumes pi(0) and advances from there
    always_comb begin
        if (init) begin
            pi_s = {AW{1'b0}};
            g_s  = mod_add(f1, f2, k);
            d_d  = mod_add(f2, f2, k);
        end else begin
            pi_s = pi_q;
            g_s  = g_q;
            d_d  = d_q;
        end
        if (step) begin
            pi_d = mod_add(pi_s, g_s, k);
            g_d  = mod_add(g_s, d_d, k);
        end else begin
            pi_d = pi_s;
            g_d  = g_s;
        end
        addr = pi_s;
    end

    // generator state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pi_q <= {AW{1'b0}};
            g_q  <= {AW{1'b0}};
            d_q  <= {AW{1'b0}};
        end else begin
            pi_q <= pi_d;
            g_q  <= g_d;
            d_q  <= d_d;
        end
    end

endmodule

// File: rtl/qpp_interleaver.sv
// Single-bank fill-then-drain buffer that replays one code block of extrinsics in QPP
// interleaved or deinterleaved order, with a 2-entry skid buffer on the output.
module qpp_interleaver
    import qpp_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    qpp_if.slave  bus
);

    state_e        state_q, state_d;
    logic [AW-1:0] k_q, k_d, f1_q, f1_d, f2_q, f2_d;
    logic          deint_q, deint_d;
    logic [AW:0]   wcnt_q, wcnt_d, rcnt_q, rcnt_d, ocnt_q, ocnt_d;
    logic          rd_valid_q, rd_valid_d;
    logic [DW-1:0] rd_data_q;
    logic [DW-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          valid_q, valid_d, busy_q, busy_d, done_q, done_d;
    logic          cfg_err_q, cfg_err_d, ovf_err_q, ovf_err_d;
    logic          cfg_ok_s, wr_en_s, rd_en_s, pop_s, gen_init_s, gen_step_s;
    logic [1:0]    occ_s;
    logic [AW-1:0] gen_addr_s, wa_s, ra_s;
    logic [DW-1:0] mem [KMAX];

    qpp_addr_gen u_gen (
        .clk  (clk),
        .rst  (rst),
        .k    (k_q),
        .f1   (f1_q),
        .f2   (f2_q),
        .init (gen_init_s),
        .step (gen_step_s),
        .addr (gen_addr_s)
    );

    // address selection and read issue; a read goes out only if the skid buffer can absorb it
    always_comb begin
        cfg_ok_s   = (bus.blklen >= 16'(KMIN)) && (bus.blklen <= 16'(KMAX)) &&
                     (bus.f1 < bus.blklen) && (bus.f2 < bus.blklen);
        pop_s      = valid_q && bus.ready_apriori;
        occ_s      = cnt_q + {1'b0, rd_valid_q} - {1'b0, pop_s};
        wr_en_s    = (state_q == FILL) && bus.valid_extrinsic;
        rd_en_s    = (state_q == DRAIN) && (rcnt_q != {1'b0, k_q}) && (occ_s < 2'd2);
        gen_init_s = (state_q == PREP) || ((state_q == FILL) && (wcnt_q == CNT_ZERO));
        gen_step_s = deint_q ? wr_en_s : rd_en_s;
        wa_s       = deint_q ? gen_addr_s : wcnt_q[AW-1:0];
        ra_s       = deint_q ? rcnt_q[AW-1:0] : gen_addr_s;
    end

    // block sequencing, counters and sticky error flags
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        f1_d      = f1_q;
        f2_d      = f2_q;
        deint_d   = deint_q;
        wcnt_d    = wcnt_q;
        rcnt_d    = rcnt_q;
        ocnt_d    = ocnt_q;
        done_d    = 1'b0;
        cfg_err_d = cfg_err_q | (bus.valid_blklen & ((state_q != IDLE) | ~cfg_ok_s));
        ovf_err_d = ovf_err_q | (bus.valid_extrinsic & (state_q != FILL));
        case (state_q)
            IDLE: begin
                if (bus.valid_blklen && cfg_ok_s) begin
                    state_d = FILL;
                    k_d     = bus.blklen[AW-1:0];
                    f1_d    = bus.f1[AW-1:0];
                    f2_d    = bus.f2[AW-1:0];
                    deint_d = bus.deint;
                    wcnt_d  = CNT_ZERO;
                end else begin
                    state_d = IDLE;
                end
            end
            FILL: begin
                if (wr_en_s) begin
                    wcnt_d  = wcnt_q + CNT_ONE;
                    state_d = ((wcnt_q + CNT_ONE) == {1'b0, k_q}) ? PREP : FILL;
                end else begin
                    state_d = FILL;
                end
            end
            PREP: begin
                state_d = DRAIN;
                rcnt_d  = CNT_ZERO;
                ocnt_d  = CNT_ZERO;
            end
            DRAIN: begin
                if (rd_en_s) begin
                    rcnt_d = rcnt_q + CNT_ONE;
                end else begin
                    rcnt_d = rcnt_q;
                end
                if (pop_s && ((ocnt_q + CNT_ONE) == {1'b0, k_q})) begin
                    ocnt_d  = ocnt_q + CNT_ONE;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (pop_s) begin
                    ocnt_d  = ocnt_q + CNT_ONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // skid buffer: e0 is the presented sample, e1 catches a read that lands during a stall
    always_comb begin
        e0_d       = e0_q;
        e1_d       = e1_q;
        cnt_d      = cnt_q;
        rd_valid_d = rd_en_s;
        case (cnt_q)
            2'd0: begin
                if (rd_valid_q) begin
                    e0_d  = rd_data_q;
                    cnt_d = 2'd1;
                end else begin
                    cnt_d = 2'd0;
                end
            end
            2'd1: begin
                if (rd_valid_q && pop_s) begin
                    e0_d = rd_data_q;
                end else if (rd_valid_q) begin
                    e1_d  = rd_data_q;
                    cnt_d = 2'd2;
                end else if (pop_s) begin
                    cnt_d = 2'd0;
                end else begin
                    cnt_d = 2'd1;
                end
            end
            2'd2: begin
                if (pop_s && rd_valid_q) begin
                    e0_d = e1_q;
                    e1_d = rd_data_q;
                end else if (pop_s) begin
                    e0_d  = e1_q;
                    cnt_d = 2'd1;
                end else begin
                    cnt_d = 2'd2;
                end
            end
            default: cnt_d = 2'd0;
        endcase
        valid_d = (cnt_d != 2'd0);
    end

    // block RAM: write during FILL, registered read during DRAIN
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem[wa_s] <= bus.extrinsic;
        end
        if (rd_en_s) begin
            rd_data_q <= mem[ra_s];
        end
    end

    // control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= {AW{1'b0}};
            f1_q       <= {AW{1'b0}};
            f2_q       <= {AW{1'b0}};
            deint_q    <= 1'b0;
            wcnt_q     <= CNT_ZERO;
            rcnt_q     <= CNT_ZERO;
            ocnt_q     <= CNT_ZERO;
            rd_valid_q <= 1'b0;
            e0_q       <= {DW{1'b0}};
            e1_q       <= {DW{1'b0}};
            cnt_q      <= 2'd0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
            ovf_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            f1_q       <= f1_d;
            f2_q       <= f2_d;
            deint_q    <= deint_d;
            wcnt_q     <= wcnt_d;
            rcnt_q     <= rcnt_d;
            ocnt_q     <= ocnt_d;
            rd_valid_q <= rd_valid_d;
            e0_q       <= e0_d;
            e1_q       <= e1_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            cfg_err_q  <= cfg_err_d;
            ovf_err_q  <= ovf_err_d;
        end
    end

    assign bus.apriori       = e0_q;
    assign bus.valid_apriori = valid_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.cfg_err       = cfg_err_q;
    assign bus.ovf_err       = ovf_err_q;

endmodule

// File: tb/tb_qpp_interleaver.sv
// Directed-sequence bench for qpp_interleaver: random/ramp blocks checked against a
// direct-multiplication QPP reference, plus error, stall and reset scenarios.
module tb_qpp_interleaver;
    import qpp_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    qpp_if bus ();

    qpp_interleaver dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int first_cyc;
    logic [DW-1:0] din[$];
    logic [DW-1:0] got[$];
    logic [DW-1:0] expq[$];
    logic [DW-1:0] saved[$];
    logic [DW-1:0] ramp40[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int pi_f(input int k, input int f1, input int f2, input int i);
        return int'((longint'(f1) * i + longint'(f2) * i * i) % k);
    endfunction

    task automatic build_model(input int k, input int f1, input int f2, input bit deint);
        logic [DW-1:0] m [];
        m = new[k];
        expq.delete();
        if (deint) begin
            for (int i = 0; i < k; i++) m[pi_f(k, f1, f2, i)] = din[i];
            for (int j = 0; j < k; j++) expq.push_back(m[j]);
        end else begin
            for (int j = 0; j < k; j++) expq.push_back(din[pi_f(k, f1, f2, j)]);
        end
    endtask

    task automatic cmp_block(input string tag);
        int bad = 0;
        int first = 0;
        chk({tag, " count"}, 32'(got.size()), 32'(expq.size()));
        for (int i = 0; i < got.size() && i < expq.size(); i++) begin
            if (got[i] !== expq[i]) begin
                if (bad == 0) first = i;
                bad++;
            end
        end
        checks++;
        assert (bad === 0) else begin
            errors++;
            $error("FAIL %s data: %0d bad samples, first at %0d observed=%0d expected=%0d",
                   tag, bad, first, got[first], expq[first]);
        end
    endtask

    task automatic cfg(input int k, input int f1, input int f2, input bit deint);
        bus.blklen       = 16'(k);
        bus.f1           = 16'(f1);
        bus.f2           = 16'(f2);
        bus.deint        = deint;
        bus.valid_blklen = 1'b1;
        @(posedge clk); #1;
        bus.valid_blklen = 1'b0;
    endtask

    task automatic fill(input int cfg_at);
        for (int i = 0; i < din.size(); i++) begin
            bus.valid_extrinsic = 1'b1;
            bus.extrinsic       = din[i];
            bus.valid_blklen    = (i == cfg_at);
            bus.blklen          = 16'd100;
            bus.f1              = 16'd1;
            bus.f2              = 16'd2;
            @(posedge clk); #1;
        end
        bus.valid_extrinsic = 1'b0;
        bus.valid_blklen    = 1'b0;
    endtask

    task automatic drain(input int limit, input bit rand_ready, input int inj_cyc);
        int cyc = 0;
        bit stall = 1'b0;
        bit rdy;
        logic [DW-1:0] held = 16'd0;
        got.delete();
        first_cyc = -1;
        while (got.size() < limit && cyc < 20000) begin
            rdy = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            bus.ready_apriori   = rdy;
            bus.valid_extrinsic = (cyc == inj_cyc);
            bus.extrinsic       = 16'hbeef;
            if (stall) begin
                chk("stall valid held", 32'(bus.valid_apriori), 32'd1);
                chk("stall data held", 32'(bus.apriori), 32'(held));
            end
            if (bus.valid_apriori === 1'b1) begin
                if (first_cyc < 0) first_cyc = cyc;
                if (rdy) got.push_back(bus.apriori);
            end
            stall = (bus.valid_apriori === 1'b1) && !rdy;
            held  = bus.apriori;
            @(posedge clk); #1;
            cyc++;
        end
        bus.ready_apriori   = 1'b0;
        bus.valid_extrinsic = 1'b0;
        chk("drain sample count", 32'(got.size()), 32'(limit));
    endtask

    task automatic run_block(input string tag, input int k, input int f1, input int f2,
                             input bit deint, input bit rr, input int cfg_at, input int inj);
        cfg(k, f1, f2, deint);
        chk({tag, " busy after cfg"}, 32'(bus.busy), 32'd1);
        fill(cfg_at);
        drain(k, rr, inj);
        if (!rr) chk({tag, " first valid latency"}, 32'(first_cyc), 32'd3);
        chk({tag, " done pulse"}, 32'(bus.done), 32'd1);
        chk({tag, " busy after done"}, 32'(bus.busy), 32'd0);
        chk({tag, " valid after done"}, 32'(bus.valid_apriori), 32'd0);
        @(posedge clk); #1;
        chk({tag, " done one cycle"}, 32'(bus.done), 32'd0);
        build_model(k, f1, f2, deint);
        cmp_block(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic scen1(input string tag);
        din = ramp40;
        run_block(tag, 40, 3, 10, 1'b0, 1'b0, -1, -1);
        chk({tag, " out0"}, 32'(got[0]), 32'd0);
        chk({tag, " out1"}, 32'(got[1]), 32'd13);
        chk({tag, " out2"}, 32'(got[2]), 32'd6);
        chk({tag, " out3"}, 32'(got[3]), 32'd19);
        chk({tag, " cfg_err clear"}, 32'(bus.cfg_err), 32'd0);
        chk({tag, " ovf_err clear"}, 32'(bus.ovf_err), 32'd0);
    endtask

    initial begin
        bus.blklen = 16'd0; bus.f1 = 16'd0; bus.f2 = 16'd0; bus.deint = 1'b0;
        bus.valid_blklen = 1'b0; bus.extrinsic = 16'd0; bus.valid_extrinsic = 1'b0;
        bus.ready_apriori = 1'b0;
        for (int i = 0; i < 40; i++) ramp40.push_back(DW'(i));

        repeat (3) @(posedge clk);
        #1;
        chk("reset apriori", 32'(bus.apriori), 32'd0);
        chk("reset valid", 32'(bus.valid_apriori), 32'd0);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset cfg_err", 32'(bus.cfg_err), 32'd0);
        chk("reset ovf_err", 32'(bus.ovf_err), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        scen1("s1");

        din = ramp40;
        run_block("s2 deint", 40, 3, 10, 1'b1, 1'b0, -1, -1);
        chk("s2 out13", 32'(got[13]), 32'd1);
        chk("s2 out6", 32'(got[6]), 32'd2);
        chk("s2 out19", 32'(got[19]), 32'd3);
        din = got;
        run_block("s2 reinterleave", 40, 3, 10, 1'b0, 1'b0, -1, -1);
        expq = ramp40;
        cmp_block("s2 roundtrip");

        din.delete();
        for (int i = 0; i < 6144; i++) din.push_back(DW'(i));
        run_block("s3 kmax", 6144, 263, 480, 1'b0, 1'b0, -1, -1);
        chk("s3 out1", 32'(got[1]), 32'd743);
        chk("s3 out2", 32'(got[2]), 32'd2446);

        din.delete();
        for (int i = 0; i < 512; i++) din.push_back(DW'($urandom));
        run_block("s4 ready1", 512, 31, 64, 1'b0, 1'b0, -1, -1);
        saved = got;
        run_block("s4 randready", 512, 31, 64, 1'b0, 1'b1, -1, -1);
        expq = saved;
        cmp_block("s4 vs ready1");

        cfg(39, 3, 10, 1'b0);
        chk("k39 cfg_err", 32'(bus.cfg_err), 32'd1);
        chk("k39 busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        chk("k39 still idle", 32'(bus.busy), 32'd0);
        do_reset();
        chk("cfg_err cleared by rst", 32'(bus.cfg_err), 32'd0);

        din.delete();
        for (int i = 0; i < 40; i++) din.push_back(DW'($urandom));
        run_block("midfill cfg", 40, 3, 10, 1'b0, 1'b0, 20, -1);
        chk("midfill cfg_err", 32'(bus.cfg_err), 32'd1);
        chk("midfill ovf_err", 32'(bus.ovf_err), 32'd0);
        do_reset();

        run_block("drain ovf", 40, 3, 10, 1'b0, 1'b0, -1, 5);
        chk("drain ovf_err", 32'(bus.ovf_err), 32'd1);
        chk("drain ovf cfg_err", 32'(bus.cfg_err), 32'd0);
        do_reset();

        din.delete();
        for (int i = 0; i < 512; i++) din.push_back(DW'($urandom));
        cfg(512, 31, 64, 1'b0);
        fill(-1);
        drain(100, 1'b0, 50);
        chk("middrain ovf set", 32'(bus.ovf_err), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("middrain rst valid", 32'(bus.valid_apriori), 32'd0);
        chk("middrain rst apriori", 32'(bus.apriori), 32'd0);
        chk("middrain rst busy", 32'(bus.busy), 32'd0);
        chk("middrain rst done", 32'(bus.done), 32'd0);
        chk("middrain rst cfg_err", 32'(bus.cfg_err), 32'd0);
        chk("middrain rst ovf_err", 32'(bus.ovf_err), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("after rst no output", 32'(bus.valid_apriori), 32'd0);
        scen1("post-rst s1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
